// File: rtl/pipe_pkg.sv
// Shared definitions for the scoreboard pipeline: register-address width and the
// per-stage control header that travels alongside each payload word.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
    } stage_hdr_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register slot: holds {header, data}; kill wins over load, load over clear.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             kill,
    input  logic             clear,
    input  stage_hdr_t       hdr_in,
    input  logic [WIDTH-1:0] data_in,
    output stage_hdr_t       hdr_out,
    output logic [WIDTH-1:0] data_out
);

    typedef struct packed {
        stage_hdr_t       hdr;
        logic [WIDTH-1:0] data;
    } stage_entry_t;

    stage_entry_t entry_d, entry_q;

    always_comb begin
        entry_d = entry_q;
        if (kill) begin
            entry_d = '0;
        end else if (load) begin
            // Bubbles are stored as all-zero so an empty slot never carries stale payload.
            if (hdr_in.valid) begin
                entry_d = '{hdr: hdr_in, data: data_in};
            end else begin
                entry_d = '0;
            end
        end else if (clear) begin
            entry_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign hdr_out  = entry_q.hdr;
    assign data_out = entry_q.data;

endmodule

// File: rtl/pipeline_scoreboard_chain.sv
// Elastic result pipeline with per-stage destination tracking, operand forwarding
// lookup, partial flush of the youngest stages and a saturating stall counter.
module pipeline_scoreboard_chain
    import pipe_pkg::*;
#(
    parameter int  WIDTH        = 32,
    parameter int  STAGES       = 4,
    parameter int  FLUSH_STAGES = 2,
    localparam int OCC_W        = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_we,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_we,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    output logic                  hit_rs1,
    output logic                  hit_rs2,
    output logic [WIDTH-1:0]      fwd_data_rs1,
    output logic [WIDTH-1:0]      fwd_data_rs2,
    output logic [OCC_W-1:0]      occupancy,
    output logic [31:0]           stall_cycles
);

    typedef struct packed {
        logic             hit;
        logic [WIDTH-1:0] data;
    } fwd_t;

    stage_hdr_t [STAGES-1:0]             hdr_s;
    logic       [STAGES-1:0][WIDTH-1:0]  data_s;
    logic       [STAGES-1:0]             vld_s;
    logic       [STAGES-1:0]             adv;
    logic       [31:0]                   stall_cycles_d, stall_cycles_q;
    fwd_t                                fwd1, fwd2;

    // Youngest matching stage wins: scan oldest to youngest so the last hit overrides.
    function automatic fwd_t fwd_lookup(input logic [REG_ADDR_W-1:0]          q,
                                        input stage_hdr_t [STAGES-1:0]        hdr,
                                        input logic [STAGES-1:0][WIDTH-1:0]   data);
        fwd_t res;
        res = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (q != ZERO_REG && hdr[k].valid && hdr[k].we && hdr[k].rd == q) begin
                res.hit  = 1'b1;
                res.data = data[k];
            end
        end
        return res;
    endfunction

    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int k = 0; k < STAGES; k++) begin
            n = n + OCC_W'(v[k]);
        end
        return n;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // Ready ripples back from the consumer: a stage moves if the next one is empty or moving.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !vld_s[k+1] || adv[k+1];
        end
    end

    assign in_ready = resetn && !flush && (!vld_s[0] || adv[0]);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_hdr_t       hdr_nx;
        logic [WIDTH-1:0] data_nx;
        logic             load_k;

        if (k == 0) begin : g_head
            assign load_k  = in_ready;
            assign hdr_nx  = '{valid: in_valid, rd: in_rd, we: in_we};
            assign data_nx = in_data;
        end else begin : g_tail
            // The first surviving stage takes a bubble when its feeder is being flushed.
            assign load_k  = adv[k-1];
            assign hdr_nx  = '{valid: hdr_s[k-1].valid && !(flush && (k <= FLUSH_STAGES)),
                               rd:    hdr_s[k-1].rd,
                               we:    hdr_s[k-1].we};
            assign data_nx = data_s[k-1];
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .resetn   (resetn),
            .load     (load_k),
            .kill     (flush && (k < FLUSH_STAGES)),
            .clear    (adv[k] && !load_k),
            .hdr_in   (hdr_nx),
            .data_in  (data_nx),
            .hdr_out  (hdr_s[k]),
            .data_out (data_s[k])
        );

        assign vld_s[k] = hdr_s[k].valid;
    end

    assign out_valid = vld_s[STAGES-1];
    assign out_data  = out_valid ? data_s[STAGES-1] : '0;
    assign out_rd    = out_valid ? hdr_s[STAGES-1].rd : '0;
    assign out_we    = out_valid && hdr_s[STAGES-1].we;

    assign fwd1         = fwd_lookup(q_rs1, hdr_s, data_s);
    assign fwd2         = fwd_lookup(q_rs2, hdr_s, data_s);
    assign hit_rs1      = fwd1.hit;
    assign hit_rs2      = fwd2.hit;
    assign fwd_data_rs1 = fwd1.data;
    assign fwd_data_rs2 = fwd2.data;

    assign occupancy = popcount(vld_s);

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (in_valid && !in_ready) begin
            stall_cycles_d = sat_inc(stall_cycles_q);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_scoreboard_chain.sv
// Bench for pipeline_scoreboard_chain: directed scenarios plus random traffic against a
// slot-queue reference model of the pipeline.
module tb_pipeline_scoreboard_chain;

    localparam int S = 4;
    localparam int F = 2;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [4:0]   in_rd = '0;
    logic         in_we = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [4:0]   out_rd;
    logic         out_we;
    logic         flush = 1'b0;
    logic [4:0]   q_rs1 = '0;
    logic [4:0]   q_rs2 = '0;
    logic         hit_rs1, hit_rs2;
    logic [W-1:0] fwd_data_rs1, fwd_data_rs2;
    logic [2:0]   occupancy;
    logic [31:0]  stall_cycles;

    pipeline_scoreboard_chain #(
        .WIDTH(W), .STAGES(S), .FLUSH_STAGES(F)
    ) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
        .flush(flush), .q_rs1(q_rs1), .q_rs2(q_rs2),
        .hit_rs1(hit_rs1), .hit_rs2(hit_rs2), .fwd_data_rs1(fwd_data_rs1), .fwd_data_rs2(fwd_data_rs2),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        logic [4:0]   rd;
        bit           we;
        bit           k;
    } item_t;

    item_t        m [S];
    logic [31:0]  m_stall;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] got [$];
    logic [W-1:0] sent [4];
    int           first_ov;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < S; k++) m[k] = '{1'b0, '0, '0, 1'b0, 1'b0};
        m_stall = '0;
    endtask

    function automatic int m_occ();
        int n = 0;
        for (int k = 0; k < S; k++) if (m[k].v) n++;
        return n;
    endfunction

    // Input side frees up whenever any slot is empty or the oldest item is leaving.
    function automatic bit m_in_ready();
        return resetn && !flush && (m_occ() < S || out_ready);
    endfunction

    function automatic logic [32:0] m_fwd(input logic [4:0] q);
        for (int k = 0; k < S; k++)
            if (q != 0 && m[k].v && m[k].we && m[k].rd == q) return {1'b1, m[k].d};
        return '0;
    endfunction

    task automatic model_step();
        bit rdy, acc;
        rdy = m_in_ready();
        acc = in_valid && rdy;
        if (in_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        for (int k = 0; k < S; k++) m[k].k = flush && (k < F);
        if (out_ready) m[S-1].v = 1'b0;
        for (int k = S - 1; k >= 1; k--) begin
            if (!m[k].v) begin
                m[k] = m[k-1];
                m[k-1].v = 1'b0;
            end
        end
        for (int k = 0; k < S; k++) if (m[k].k) m[k].v = 1'b0;
        if (acc) m[0] = '{1'b1, in_data, in_rd, in_we, 1'b0};
    endtask

    task automatic check_all();
        logic [32:0] e1, e2;
        e1 = m_fwd(q_rs1);
        e2 = m_fwd(q_rs2);
        chk("out_valid", 64'(out_valid), 64'(m[S-1].v));
        chk("out_data", 64'(out_data), 64'(m[S-1].v ? m[S-1].d : 32'd0));
        chk("out_rd", 64'(out_rd), 64'(m[S-1].v ? m[S-1].rd : 5'd0));
        chk("out_we", 64'(out_we), 64'(m[S-1].v && m[S-1].we));
        chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
        chk("occupancy", 64'(occupancy), 64'(m_occ()));
        chk("hit_rs1", 64'(hit_rs1), 64'(e1[32]));
        chk("fwd_rs1", 64'(fwd_data_rs1), 64'(e1[31:0]));
        chk("hit_rs2", 64'(hit_rs2), 64'(e2[32]));
        chk("fwd_rs2", 64'(fwd_data_rs2), 64'(e2[31:0]));
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    endtask

    task automatic cyc();
        #1;
        check_all();
        if (out_valid && out_ready) got.push_back(out_data);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [4:0] rd, input logic we);
        in_valid = v;
        in_data  = d;
        in_rd    = rd;
        in_we    = we;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        m_reset();
        resetn = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);
        cyc();

        // Back-to-back stream
        out_ready = 1'b1;
        got.delete();
        first_ov = -1;
        for (int i = 0; i < 12; i++) begin
            if (i < 6) drive(1'b1, 32'h11 + 32'(i), 5'(i + 1), 1'b1);
            else       drive(1'b0, '0, '0, 1'b0);
            #1;
            if (out_valid && first_ov < 0) first_ov = i;
            cyc();
        end
        chk("stream_latency", 64'(first_ov), 64'd4);
        chk("stream_count", 64'(got.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < got.size()) chk("stream_data", 64'(got[i]), 64'(32'h11 + 32'(i)));
        chk("stream_stall", 64'(stall_cycles), 64'd0);

        // Backpressure
        out_ready = 1'b0;
        got.delete();
        for (int i = 0; i < 9; i++) begin
            if (i < 4) begin
                sent[i] = $urandom;
                drive(1'b1, sent[i], 5'(i + 8), 1'b1);
            end
            cyc();
        end
        #1;
        chk("bp_occupancy", 64'(occupancy), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_stall", 64'(stall_cycles), 64'd5);
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("bp_count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) chk("bp_data", 64'(got[i]), 64'(sent[i]));

        // Flush of the two youngest stages
        out_ready = 1'b0;
        got.delete();
        sent = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sent[i], 5'(i + 1), 1'b1);
            cyc();
        end
        drive(1'b0, '0, '0, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        chk("flush_occupancy", 64'(occupancy), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("flush_count", 64'(got.size()), 64'd2);
        if (got.size() > 0) chk("flush_first", 64'(got[0]), 64'h0A1);
        if (got.size() > 1) chk("flush_second", 64'(got[1]), 64'h0B2);

        // Forwarding priority and qualifiers
        out_ready = 1'b0;
        drive(1'b1, 32'hBB, 5'd5, 1'b1); cyc();
        drive(1'b1, 32'h77, 5'd0, 1'b1); cyc();
        drive(1'b1, 32'hAA, 5'd5, 1'b1); cyc();
        drive(1'b1, 32'h99, 5'd7, 1'b0); cyc();
        drive(1'b0, '0, '0, 1'b0);
        q_rs1 = 5'd5;
        q_rs2 = 5'd0;
        #1;
        chk("fwd_youngest_hit", 64'(hit_rs1), 64'd1);
        chk("fwd_youngest_data", 64'(fwd_data_rs1), 64'h0AA);
        chk("fwd_x0_hit", 64'(hit_rs2), 64'd0);
        chk("fwd_x0_data", 64'(fwd_data_rs2), 64'd0);
        q_rs2 = 5'd7;
        #1;
        chk("fwd_we0_hit", 64'(hit_rs2), 64'd0);
        chk("fwd_we0_data", 64'(fwd_data_rs2), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        q_rs1 = '0;
        q_rs2 = '0;

        // Asynchronous reset with items in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 5'(i + 1), 1'b1);
            cyc();
        end
        drive(1'b0, '0, '0, 1'b0);
        cyc();
        q_rs1 = 5'd1;
        #1;
        chk("pre_rst_occupancy", 64'(occupancy), 64'd3);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_occupancy", 64'(occupancy), 64'd0);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        chk("mid_rst_stall", 64'(stall_cycles), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_hit", 64'(hit_rs1), 64'd0);
        m_reset();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        got.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("post_rst_no_output", 64'(got.size()), 64'd0);
        q_rs1 = '0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_rd     = 5'($urandom_range(0, 7));
            in_we     = ($urandom_range(0, 1) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            q_rs1     = 5'($urandom_range(0, 7));
            q_rs2     = 5'($urandom_range(0, 7));
            cyc();
        end

        // Stall counter saturation
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h5A5A_0001, 5'd3, 1'b1);
        for (int i = 0; i < 6; i++) cyc();
        #1;
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        m_stall = 32'hFFFF_FFFE;
        chk("sat_preload", 64'(stall_cycles), 64'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) cyc();
        #1;
        chk("sat_hold", 64'(stall_cycles), 64'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_scoreboard_chain.md
PIPELINE_SCOREBOARD_CHAIN -- requirements
Module: pipeline_scoreboard_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload (result) width per stage.
REQ-002 SHALL have parameter STAGES, default 4, range 2..8, number of register stages.
REQ-003 SHALL have parameter FLUSH_STAGES, default 2, range 1..STAGES, number of youngest stages killed by flush.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1, in_data in WIDTH, in_rd in 5, in_we in 1: producer side, transfer on in_valid && in_ready.
REQ-007 SHALL have ports out_valid out 1, out_ready in 1, out_data out WIDTH, out_rd out 5, out_we out 1: oldest stage (STAGES-1) to consumer.
REQ-008 SHALL have port flush  in  1  kill contents of stages 0..FLUSH_STAGES-1 (branch taken).
REQ-009 SHALL have ports q_rs1, q_rs2  in  5  source register queries.
REQ-010 SHALL have ports hit_rs1, hit_rs2  out  1, fwd_data_rs1, fwd_data_rs2  out  WIDTH: forwarding result per query.
REQ-011 SHALL have port occupancy  out  clog2(STAGES+1)  count of valid stages.
REQ-012 SHALL have port stall_cycles  out  32  saturating count of cycles with in_valid && !in_ready.

Function
REQ-013 Each stage k SHALL hold valid, data, rd, we; stage 0 youngest, stage STAGES-1 oldest.
REQ-014 Stage STAGES-1 SHALL advance when out_ready; stage k<STAGES-1 SHALL advance when stage k+1 is empty or advances (combinational ready ripple, no bubble required).
REQ-015 in_ready SHALL equal (!valid[0] || advance[0]) && !flush.
REQ-016 A stage that advances without receiving new contents SHALL become invalid next cycle.
REQ-017 Latency SHALL be STAGES cycles from accepted input to out_valid with no backpressure; throughput one item per cycle.
REQ-018 On flush, stages 0..FLUSH_STAGES-1 SHALL be invalid next cycle, contents present before the edge are killed and not moved forward; stage FLUSH_STAGES SHALL become invalid if it advanced in that cycle.
REQ-019 Flush SHALL NOT affect stages FLUSH_STAGES..STAGES-1 other than REQ-018; output handshake continues normally.
REQ-020 hit_rsN SHALL be 1 iff q_rsN != 0 and some stage has valid && we && rd == q_rsN; purely combinational from registered state.
REQ-021 fwd_data_rsN SHALL be data of the youngest (lowest index) matching stage; 0 when hit_rsN is 0.
REQ-022 out_data/out_rd/out_we SHALL be 0 when out_valid is 0.
REQ-023 occupancy SHALL be registered-state popcount of valid bits (0..STAGES).
REQ-024 stall_cycles SHALL increment per cycle with in_valid && !in_ready, saturate at 0xFFFFFFFF, never wrap.

Reset
REQ-025 resetn low SHALL immediately clear all valid bits, data, rd, we, stall_cycles to 0, regardless of clk.
REQ-026 During reset in_ready SHALL be 0; after deassertion in_ready SHALL be 1 on the first cycle.
REQ-027 Reset mid-operation SHALL discard all in-flight items; no output after reset until a new item traverses STAGES cycles.

Structure
REQ-028 Shared package pipe_pkg SHALL hold REG_ADDR_W = 5, ZERO_REG = 0, and the stage-entry struct (valid, rd, we, data) parameterised by WIDTH.
REQ-029 One sub-module pipe_stage SHALL implement a single stage register with load, kill and clear inputs; chain built by generate loop.
REQ-030 Forwarding priority search SHALL be a function in the module, not a sub-module.

Verification (STAGES=4, FLUSH_STAGES=2, WIDTH=32)
REQ-031 Stream: inputs 0x11..0x16 rd=1..6 we=1 back-to-back, out_ready=1 -> out_valid first at cycle 4 after first accept, outputs 0x11..0x16 in order, stall_cycles=0.
REQ-032 Backpressure: fill 4 items, out_ready=0 for 5 cycles with in_valid=1 -> occupancy=4, in_ready=0, stall_cycles=5; release -> all items delivered, no loss/duplication.
REQ-033 Flush: 4 items A,B,C,D in stages 3..0, out_ready=0, flush 1 cycle -> C,D removed, occupancy=2, later outputs A,B only.
REQ-034 Forwarding: stage1 rd=5 data=0xAA, stage3 rd=5 data=0xBB, q_rs1=5 -> hit_rs1=1, fwd_data_rs1=0xAA; q_rs2=0 with rd=0 entry -> hit_rs2=0, fwd 0; we=0 entry -> no hit.
REQ-035 Reset mid-stream: resetn low between edges with occupancy=3 -> valid bits, outputs, stall_cycles 0 immediately; after release in_ready=1.
REQ-036 Saturation: force stall_cycles near max (0xFFFFFFFE), stall 3 cycles -> holds 0xFFFFFFFF.
